// File: rtl/prbs_ber_rx.sv
// prbs_ber_rx: PRBS9 receive checker. It slices the symbol stream, searches for the link delay, and counts bit errors while locked.
// Optional macro PRBS_RX_SAT_EN makes the bit and error counters saturate at all-ones instead of wrapping.
module prbs_ber_rx #(
   parameter int NB_DATA    = 13,
   parameter int NB_DLY     = 4,
   parameter int NB_CNT     = 32,
   parameter int SEARCH_WIN = 64,
   parameter int LOSS_THR   = 8
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic              i_enable,
   input  logic [NB_DATA-1:0] i_data,
   output logic              o_lock,
   output logic [NB_DLY-1:0] o_delay,
   output logic [NB_CNT-1:0] o_bit_count,
   output logic [NB_CNT-1:0] o_err_count
);
   localparam int HIST_LEN = 2**NB_DLY;
   localparam int NB_WIN   = $clog2(SEARCH_WIN + 1);

   typedef enum logic [0:0] {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t              state_r, state_s;
   logic [8:0]          prbs_r, prbs_s;
   logic [HIST_LEN-1:0] hist_r, hist_s;
   logic [NB_DLY-1:0]   delay_r, delay_s;
   logic [NB_WIN-1:0]   win_cnt_r, win_cnt_s;
   logic [NB_WIN-1:0]   win_err_r, win_err_s, win_sum_s;
   logic [NB_CNT-1:0]   bit_cnt_r, bit_cnt_s;
   logic [NB_CNT-1:0]   err_cnt_r, err_cnt_s;
   logic                lock_r;
   logic                step_s, rx_bit_s, err_s, win_end_s;
   logic                unused_data_s;

   // Slicer and per-step error against the delayed local replica (the slicer only needs the sign bit).
   always_comb begin
      step_s        = i_valid & i_enable;
      rx_bit_s      = ~i_data[NB_DATA-1];
      unused_data_s = ^i_data[NB_DATA-2:0];
      err_s         = rx_bit_s ^ hist_r[delay_r];
      win_sum_s     = win_err_r + NB_WIN'(err_s);
      win_end_s     = (win_cnt_r == NB_WIN'(SEARCH_WIN - 1));
   end

   // Local PRBS9 generator and reference history; both advance only on a step.
   always_comb begin
      prbs_s = prbs_r;
      hist_s = hist_r;
      if (step_s) begin
         prbs_s = {prbs_r[7:0], prbs_r[8] ^ prbs_r[4]};
         hist_s = {hist_r[HIST_LEN-2:0], prbs_r[8]};
      end else begin
         prbs_s = prbs_r;
         hist_s = hist_r;
      end
   end

   // Search/lock next-state logic, window bookkeeping and BER totals.
   always_comb begin
      state_s   = state_r;
      delay_s   = delay_r;
      win_cnt_s = win_cnt_r;
      win_err_s = win_err_r;
      bit_cnt_s = bit_cnt_r;
      err_cnt_s = err_cnt_r;
      if (step_s) begin
         case (state_r)
            ST_SEARCH: begin
               if (win_end_s) begin
                  if (win_sum_s == NB_WIN'(1'b0)) begin
                     state_s = ST_LOCKED;
                  end else begin
                     delay_s = delay_r + NB_DLY'(1'b1);
                  end
                  win_cnt_s = NB_WIN'(1'b0);
                  win_err_s = NB_WIN'(1'b0);
               end else begin
                  win_cnt_s = win_cnt_r + NB_WIN'(1'b1);
                  win_err_s = win_sum_s;
               end
            end
            ST_LOCKED: begin
`ifdef PRBS_RX_SAT_EN
               // Once bit_count pins at all-ones, both totals freeze so the ratio stays meaningful.
               if (bit_cnt_r != {NB_CNT{1'b1}}) begin
                  bit_cnt_s = bit_cnt_r + NB_CNT'(1'b1);
                  if (err_cnt_r != {NB_CNT{1'b1}}) begin
                     err_cnt_s = err_cnt_r + NB_CNT'(err_s);
                  end else begin
                     err_cnt_s = err_cnt_r;
                  end
               end else begin
                  bit_cnt_s = bit_cnt_r;
                  err_cnt_s = err_cnt_r;
               end
`else
               bit_cnt_s = bit_cnt_r + NB_CNT'(1'b1);
               err_cnt_s = err_cnt_r + NB_CNT'(err_s);
`endif
               if (win_sum_s == NB_WIN'(LOSS_THR)) begin
                  state_s   = ST_SEARCH;
                  delay_s   = delay_r + NB_DLY'(1'b1);
                  win_cnt_s = NB_WIN'(1'b0);
                  win_err_s = NB_WIN'(1'b0);
               end else if (win_end_s) begin
                  win_cnt_s = NB_WIN'(1'b0);
                  win_err_s = NB_WIN'(1'b0);
               end else begin
                  win_cnt_s = win_cnt_r + NB_WIN'(1'b1);
                  win_err_s = win_sum_s;
               end
            end
            default: begin
               state_s   = ST_SEARCH;
               delay_s   = {NB_DLY{1'b0}};
               win_cnt_s = NB_WIN'(1'b0);
               win_err_s = NB_WIN'(1'b0);
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_r   <= ST_SEARCH;
         prbs_r    <= 9'h1AA;
         hist_r    <= {HIST_LEN{1'b0}};
         delay_r   <= {NB_DLY{1'b0}};
         win_cnt_r <= {NB_WIN{1'b0}};
         win_err_r <= {NB_WIN{1'b0}};
         bit_cnt_r <= {NB_CNT{1'b0}};
         err_cnt_r <= {NB_CNT{1'b0}};
         lock_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         prbs_r    <= prbs_s;
         hist_r    <= hist_s;
         delay_r   <= delay_s;
         win_cnt_r <= win_cnt_s;
         win_err_r <= win_err_s;
         bit_cnt_r <= bit_cnt_s;
         err_cnt_r <= err_cnt_s;
         lock_r    <= (state_s == ST_LOCKED);
      end
   end

   assign o_lock      = lock_r;
   assign o_delay     = delay_r;
   assign o_bit_count = bit_cnt_r;
   assign o_err_count = err_cnt_r;
endmodule

// File: tb/tb_prbs_ber_rx.sv
// tb_prbs_ber_rx: scenario tasks driving a PRBS9 link with a 5-step lag, and a cycle-by-cycle scoreboard of all outputs.
module tb_prbs_ber_rx;
   logic        clock = 1'b0;
   logic        i_reset = 1'b1, i_valid = 1'b0, i_enable = 1'b1;
   logic [12:0] i_data = 13'h0;
   logic        o_lock, o2_lock;
   logic [3:0]  o_delay, o2_delay;
   logic [31:0] o_bit_count, o_err_count;
   logic [3:0]  o2_bit_count, o2_err_count;
   int          n_tests = 0, n_fail = 0;

   typedef struct packed {
      logic        lock;
      logic [3:0]  delay;
      logic [31:0] bits;
      logic [31:0] errs;
   } obs_t;
   obs_t sb_q[$];

   // Reference model state, then the transmitter (same seed, 5-step lag).
   logic [8:0]  m_prbs, t_prbs;
   logic [15:0] m_hist, t_hist;
   int          m_delay, m_wcnt, m_werr;
   bit          m_locked;
   logic [31:0] m_bits, m_errs;

   always #5 clock = ~clock;

   prbs_ber_rx dut (
      .clock(clock), .i_reset(i_reset), .i_valid(i_valid), .i_enable(i_enable), .i_data(i_data),
      .o_lock(o_lock), .o_delay(o_delay), .o_bit_count(o_bit_count), .o_err_count(o_err_count));

   prbs_ber_rx #(.NB_CNT(4)) dut2 (
      .clock(clock), .i_reset(i_reset), .i_valid(i_valid), .i_enable(i_enable), .i_data(i_data),
      .o_lock(o2_lock), .o_delay(o2_delay), .o_bit_count(o2_bit_count), .o_err_count(o2_err_count));

   function void model_reset();
      m_prbs = 9'h1AA; m_hist = 16'h0; m_delay = 0; m_wcnt = 0; m_werr = 0;
      m_locked = 1'b0; m_bits = 32'd0; m_errs = 32'd0;
   endfunction

   function void model_step(bit rx);
      int e;
      e = int'(rx ^ m_hist[m_delay]);
      if (!m_locked) begin
         if (m_wcnt == 63) begin
            if (m_werr + e == 0) m_locked = 1'b1;
            else m_delay = (m_delay + 1) % 16;
            m_wcnt = 0; m_werr = 0;
         end else begin
            m_wcnt++; m_werr += e;
         end
      end else begin
         m_bits = m_bits + 32'd1;
         m_errs = m_errs + 32'(e);
         if (m_werr + e == 8) begin
            m_locked = 1'b0; m_delay = (m_delay + 1) % 16; m_wcnt = 0; m_werr = 0;
         end else if (m_wcnt == 63) begin
            m_wcnt = 0; m_werr = 0;
         end else begin
            m_wcnt++; m_werr += e;
         end
      end
      m_hist = {m_hist[14:0], m_prbs[8]};
      m_prbs = {m_prbs[7:0], m_prbs[8] ^ m_prbs[4]};
   endfunction

   function logic [12:0] enc(bit b);
      if (b) enc = 13'($urandom_range(0, 4095));
      else   enc = 13'(int'($urandom_range(0, 4095)) - 4096);
   endfunction

   task automatic drive_cycle(input bit valid, input bit enable, input bit rst, input logic [12:0] data);
      obs_t exp;
      @(negedge clock);
      i_valid = valid; i_enable = enable; i_reset = rst; i_data = data;
      if (rst) model_reset();
      else if (valid && enable) model_step(~data[12]);
      exp = '{m_locked, m_delay[3:0], m_bits, m_errs};
      sb_q.push_back(exp);
      @(posedge clock);
      #2;
   endtask

   task automatic tx_reset();
      t_prbs = 9'h1AA; t_hist = 16'h0;
   endtask

   task automatic tx_step(input bit inv);
      bit b;
      b = t_hist[5];
      t_hist = {t_hist[14:0], t_prbs[8]};
      t_prbs = {t_prbs[7:0], t_prbs[8] ^ t_prbs[4]};
      drive_cycle(1'b1, 1'b1, 1'b0, enc(b ^ inv));
   endtask

   task automatic do_reset();
      drive_cycle(1'b1, 1'b1, 1'b1, 13'h0abc);
      drive_cycle(1'b1, 1'b1, 1'b1, 13'h1234);
      tx_reset();
   endtask

   task automatic run_until_lock(input int budget, output int steps);
      steps = 0;
      while (steps < budget && o_lock !== 1'b1) begin
         if ($urandom_range(0, 7) == 0) drive_cycle(1'b0, 1'b1, 1'b0, enc(1'($urandom_range(0, 1))));
         tx_step(1'b0);
         steps++;
      end
      n_tests++;
      if (o_lock !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_timeout: o_lock=%b after %0d steps, required 1", o_lock, steps);
      end
   endtask

   // Scoreboard: one expected observation per cycle, compared just after the edge.
   always @(posedge clock) begin
      obs_t exp, got;
      #1;
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         got = '{o_lock, o_delay, o_bit_count, o_err_count};
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t: lock/delay/bits/errs got %b/%0d/%0d/%0d required %b/%0d/%0d/%0d",
                     $time, got.lock, got.delay, got.bits, got.errs, exp.lock, exp.delay, exp.bits, exp.errs);
         end
      end
   end

   task automatic test_reset();
      do_reset();
      drive_cycle(1'b0, 1'b1, 1'b0, 13'h0);
      n_tests++;
      if (o_lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b required 0", o_lock); end
      n_tests++;
      if (o_delay !== 4'd0) begin n_fail++; $display("FAIL reset_delay: got %0d required 0", o_delay); end
      n_tests++;
      if (o_bit_count !== 32'd0 || o_err_count !== 32'd0) begin
         n_fail++; $display("FAIL reset_counts: got %0d/%0d required 0/0", o_bit_count, o_err_count);
      end
   endtask

   task automatic test_lock();
      int steps;
      do_reset();
      run_until_lock(2000, steps);
      n_tests++;
      if (steps !== 384) begin n_fail++; $display("FAIL lock_time: got %0d steps required 384", steps); end
      n_tests++;
      if (o_delay !== 4'd5) begin n_fail++; $display("FAIL lock_delay: got %0d required 5", o_delay); end
      for (int i = 0; i < 20; i++) tx_step(1'b0);
      n_tests++;
      if (o_bit_count !== 32'd20 || o_err_count !== 32'd0) begin
         n_fail++; $display("FAIL lock_counts: got %0d/%0d required 20/0", o_bit_count, o_err_count);
      end
   endtask

   task automatic test_single_error();
      logic [31:0] e0;
      e0 = o_err_count;
      for (int i = 0; i < 5; i++) tx_step(1'b0);
      tx_step(1'b1);
      for (int i = 0; i < 5; i++) tx_step(1'b0);
      n_tests++;
      if (o_err_count !== e0 + 32'd1 || o_lock !== 1'b1) begin
         n_fail++; $display("FAIL single_error: errs/lock got %0d/%b required %0d/1", o_err_count, o_lock, e0 + 32'd1);
      end
   endtask

   task automatic test_loss();
      int steps;
      do_reset();
      run_until_lock(2000, steps);
      for (int i = 0; i < 7; i++) tx_step(1'b1);
      n_tests++;
      if (o_lock !== 1'b1) begin n_fail++; $display("FAIL loss_below_thr: lock got %b required 1", o_lock); end
      tx_step(1'b1);
      n_tests++;
      if (o_lock !== 1'b0 || o_delay !== 4'd6 || o_err_count !== 32'd8) begin
         n_fail++; $display("FAIL loss: lock/delay/errs got %b/%0d/%0d required 0/6/8", o_lock, o_delay, o_err_count);
      end
      for (int i = 0; i < 3; i++) tx_step(1'b0);
      run_until_lock(1100, steps);
      n_tests++;
      if (steps + 3 !== 1024 || o_delay !== 4'd5) begin
         n_fail++; $display("FAIL relock: steps/delay got %0d/%0d required 1024/5", steps + 3, o_delay);
      end
      n_tests++;
      if (o_err_count !== 32'd8 || o_bit_count !== 32'd8) begin
         n_fail++; $display("FAIL relock_totals: errs/bits got %0d/%0d required 8/8", o_err_count, o_bit_count);
      end
   endtask

   task automatic test_enable();
      obs_t snap, now;
      snap = '{o_lock, o_delay, o_bit_count, o_err_count};
      for (int i = 0; i < 50; i++) begin
         drive_cycle(1'b1, 1'b0, 1'b0, 13'($urandom_range(0, 8191)));
         if (i % 10 == 0) drive_cycle(1'b0, 1'b0, 1'b0, 13'($urandom_range(0, 8191)));
      end
      now = '{o_lock, o_delay, o_bit_count, o_err_count};
      n_tests++;
      if (now !== snap) begin
         n_fail++; $display("FAIL enable_hold: bits/errs got %0d/%0d required %0d/%0d", now.bits, now.errs, snap.bits, snap.errs);
      end
      for (int i = 0; i < 30; i++) tx_step(1'b0);
      n_tests++;
      if (o_err_count !== snap.errs || o_bit_count !== snap.bits + 32'd30 || o_lock !== 1'b1) begin
         n_fail++; $display("FAIL enable_resume: bits/errs got %0d/%0d required %0d/%0d", o_bit_count, o_err_count, snap.bits + 32'd30, snap.errs);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] b0;
      b0 = o_bit_count;
      for (int i = 0; i < 64; i++) tx_step(1'b0);
      n_tests++;
      if (o_bit_count !== b0 + 32'd64) begin
         n_fail++; $display("FAIL back_to_back: bits got %0d required %0d", o_bit_count, b0 + 32'd64);
      end
   endtask

   task automatic test_midreset();
      drive_cycle(1'b1, 1'b1, 1'b1, 13'h0);
      tx_reset();
      n_tests++;
      if (o_lock !== 1'b0 || o_delay !== 4'd0 || o_bit_count !== 32'd0 || o_err_count !== 32'd0) begin
         n_fail++; $display("FAIL midreset: lock/delay/bits/errs got %b/%0d/%0d/%0d required 0/0/0/0",
                            o_lock, o_delay, o_bit_count, o_err_count);
      end
   endtask

   task automatic test_counter_limit();
      int steps;
      logic [3:0] exp_bits;
`ifdef PRBS_RX_SAT_EN
      exp_bits = 4'd15;
`else
      exp_bits = 4'd4;
`endif
      do_reset();
      run_until_lock(2000, steps);
      for (int i = 0; i < 20; i++) tx_step(1'b0);
      n_tests++;
      if (o2_bit_count !== exp_bits || o2_err_count !== 4'd0 || o2_lock !== 1'b1 || o2_delay !== 4'd5) begin
         n_fail++; $display("FAIL counter_limit: bits/errs/lock/delay got %0d/%0d/%b/%0d required %0d/0/1/5",
                            o2_bit_count, o2_err_count, o2_lock, o2_delay, exp_bits);
      end
   endtask

   initial begin
      model_reset();
      tx_reset();
      test_reset();
      test_lock();
      test_single_error();
      test_enable();
      test_back_to_back();
      test_midreset();
      test_loss();
      test_counter_limit();
      @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
